// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder: bus widths, read-pipeline
// entry and the address range test used by the array and the pipeline exit.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef struct packed {
        logic                   valid;
        logic [SRAM_ADDR_W-1:0] addr;
    } rd_entry_t;

    function automatic logic addr_in_range(input logic [SRAM_ADDR_W-1:0] addr,
                                           input int unsigned            depth);
        return ({14'd0, addr} < depth);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency shift pipeline: one {valid, addr} entry enters per clock and
// leaves READ_LAT clocks later; a synchronous active-low clear drops everything.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic      clk_i,
    input  logic      clr_n_i,
    input  rd_entry_t push_i,
    output rd_entry_t exit_o
);

    rd_entry_t stage_q [READ_LAT];

    // Shift register of in-flight reads.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_i;
            for (int i = 1; i < READ_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign exit_o = stage_q[READ_LAT-1];

endmodule

// File: rtl/sram_responder.sv
// Synchronous SRAM target: word array, fixed-latency read pipeline and DQ tristate.
// Optional macro SRAM_ACCESS_STATS_EN adds saturating read/write access counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DEPTH    = 65536,
    parameter int READ_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    input  logic                   SRAM_WE_N,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   addr_err
`ifdef SRAM_ACCESS_STATS_EN
    ,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic                   in_rng_s;
    logic                   wr_en_s;
    logic                   exit_in_rng_s;
    rd_entry_t              push_s;
    rd_entry_t              exit_s;

    logic [SRAM_DATA_W-1:0] mem_q [DEPTH];
    logic [SRAM_DATA_W-1:0] rdata_q;
    logic [SRAM_DATA_W-1:0] byp_data_q;
    logic                   byp_q;
    logic                   oor_q;
    logic                   out_vld_q;
    logic                   addr_err_q;

    logic [SRAM_DATA_W-1:0] dq_out_s;
    logic                   dq_oe_s;

    // Decode the current bus cycle.
    always_comb begin
        in_rng_s      = addr_in_range(SRAM_ADDR, 32'(DEPTH));
        wr_en_s       = rst & ~SRAM_WE_N & in_rng_s;
        push_s.valid  = SRAM_WE_N;
        push_s.addr   = SRAM_ADDR;
        exit_in_rng_s = addr_in_range(exit_s.addr, 32'(DEPTH));
    end

    sram_rd_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk_i   (clk),
        .clr_n_i (rst),
        .push_i  (push_s),
        .exit_o  (exit_s)
    );

    // Storage array; deliberately unreset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[SRAM_ADDR[IDX_W-1:0]] <= SRAM_DQ;
        end
        rdata_q <= mem_q[exit_s.addr[IDX_W-1:0]];
    end

    // Exit stage: the array read above sees pre-write data, so a write to the
    // exiting address on the same edge is bypassed to keep reads write-first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld_q  <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= {SRAM_DATA_W{1'b0}};
            oor_q      <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            out_vld_q  <= exit_s.valid;
            byp_q      <= wr_en_s && (SRAM_ADDR == exit_s.addr);
            byp_data_q <= SRAM_DQ;
            oor_q      <= ~exit_in_rng_s;
            addr_err_q <= ~in_rng_s;
        end
    end

    // Read data select and bus enable; drive only while the initiator reads.
    always_comb begin
        dq_out_s = rdata_q;
        if (oor_q) begin
            dq_out_s = {SRAM_DATA_W{1'b0}};
        end else if (byp_q) begin
            dq_out_s = byp_data_q;
        end else begin
            dq_out_s = rdata_q;
        end
        dq_oe_s = rst & out_vld_q & SRAM_WE_N;
    end

    assign SRAM_DQ  = dq_oe_s ? dq_out_s : {SRAM_DATA_W{1'bz}};
    assign addr_err = addr_err_q;

`ifdef SRAM_ACCESS_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] rd_count_d;
    logic [31:0] wr_count_q;
    logic [31:0] wr_count_d;

    // Saturating counts of accepted in-range accesses.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rst && SRAM_WE_N && in_rng_s && (rd_count_q != 32'hFFFF_FFFF)) begin
            rd_count_d = rd_count_q + 32'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
        if (wr_en_s && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed vector table for the
// latency/write-first/out-of-range/reset cases, then randomized traffic vs a model.
module tb_sram_responder;
    import sram_pkg::*;

    localparam int DEPTH = 65536;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        we_n;
    logic        tb_drv;
    logic [15:0] tb_data;
    tri1  [15:0] dq_w;
    logic        addr_err;
`ifdef SRAM_ACCESS_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    always #5 clk = ~clk;

    assign dq_w = tb_drv ? tb_data : 16'hzzzz;

    sram_responder #(
        .DEPTH    (DEPTH),
        .READ_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_ADDR (addr),
        .SRAM_WE_N (we_n),
        .SRAM_DQ   (dq_w),
        .addr_err  (addr_err)
`ifdef SRAM_ACCESS_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] bus_idle;

    // Reference model: memory as an associative array plus a queue of pending
    // reads tagged with the edge that sampled them.
    typedef struct { int edge_n; logic [17:0] a; } rd_t;
    logic [15:0] mem_m [int];
    rd_t         pend [$];
    int          edge_n    = 0;
    bit          exp_vld   = 1'b0;
    bit          exp_known = 1'b0;
    logic [15:0] exp_dat   = 16'h0000;
    logic        exp_err   = 1'b0;

    typedef struct {
        logic        r;
        logic [17:0] a;
        logic        w;
        logic [15:0] d;
        bit          drv;
        logic [15:0] dq;
        logic        err;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        rd_t e;
        edge_n++;
        exp_vld = 1'b0;
        if (!rst) begin
            pend.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = (int'(addr) >= DEPTH);
            if (!we_n && int'(addr) < DEPTH) mem_m[int'(addr)] = tb_data;
            if (we_n) pend.push_back('{edge_n, addr});
            if (pend.size() > 0 && pend[0].edge_n == edge_n - LAT) begin
                e = pend.pop_front();
                exp_vld = 1'b1;
                if (int'(e.a) >= DEPTH) begin
                    exp_dat = 16'h0000; exp_known = 1'b1;
                end else if (mem_m.exists(int'(e.a))) begin
                    exp_dat = mem_m[int'(e.a)]; exp_known = 1'b1;
                end else begin
                    exp_dat = 16'h0000; exp_known = 1'b0;
                end
            end
        end
    endtask

    // Apply one bus cycle, check the outputs visible during it, then clock it.
    task automatic step(input logic r, input logic [17:0] a, input logic w, input logic [15:0] d,
                        input bit use_tbl, input bit t_drv, input logic [15:0] t_dq,
                        input logic t_err, input string tag);
        bit          e_drv;
        bit          e_known;
        logic [15:0] e_dq;
        logic        e_err;
        rst = r; addr = a; we_n = w; tb_drv = ~w; tb_data = d;
        #2;
        if (use_tbl) begin
            e_drv = t_drv; e_known = 1'b1; e_dq = t_dq; e_err = t_err;
        end else begin
            e_drv = exp_vld && w && r; e_known = exp_known; e_dq = exp_dat; e_err = exp_err;
        end
        if (e_drv) begin
            if (e_known) check({tag, " dq"}, {16'h0000, dq_w}, {16'h0000, e_dq});
        end else if (w) begin
            check({tag, " hiz"}, {16'h0000, dq_w}, {16'h0000, bus_idle});
        end else begin
            check({tag, " wbus"}, {16'h0000, dq_w}, {16'h0000, d});
        end
        check({tag, " err"}, {31'd0, addr_err}, {31'd0, e_err});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic add(input logic r, input logic [17:0] a, input logic w, input logic [15:0] d,
                       input bit drv, input logic [15:0] dq, input logic err);
        tbl.push_back('{r, a, w, d, drv, dq, err});
    endtask

    initial begin
        rst = 1'b0; addr = 18'd0; we_n = 1'b1; tb_drv = 1'b0; tb_data = 16'h0000;
        #2;
        bus_idle = dq_w;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); model_edge(); #1;
        end

        //   rst  addr        we_n  data      drv  dq        err
        add(1'b0, 18'd0,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0); // reset state
        add(1'b1, 18'd5,     1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd0,     1'b0, 16'h00A0, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd1,     1'b0, 16'h00A1, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd2,     1'b0, 16'h00A2, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd3,     1'b0, 16'h00A3, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd9,     1'b0, 16'h5A5A, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd5,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0); // read 5
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd1,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd2,     1'b1, 16'h0000, 1'b1, 16'h1234, 1'b0); // 2 edges after read 5
        add(1'b1, 18'd3,     1'b1, 16'h0000, 1'b1, 16'h00A0, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h00A1, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h00A2, 1'b0);
        add(1'b1, 18'd7,     1'b1, 16'h0000, 1'b1, 16'h00A3, 1'b0); // read 7
        add(1'b1, 18'd7,     1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0); // write 7, exit discarded
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h00A0, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'hBEEF, 1'b0); // write-first
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'h10000, 1'b0, 16'hDEAD, 1'b0, 16'h0000, 1'b0); // oor write
        add(1'b1, 18'h10000, 1'b1, 16'h0000, 1'b1, 16'h00A0, 1'b1); // oor read
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h00A0, 1'b1);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'h10000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0); // oor data; second in-flight read
        add(1'b0, 18'd9,     1'b0, 16'h1111, 1'b0, 16'h0000, 1'b1); // reset, write suppressed
        add(1'b1, 18'd9,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd9,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h5A5A, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h5A5A, 1'b0);
        add(1'b1, 18'd0,     1'b1, 16'h0000, 1'b1, 16'h00A0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].d, 1'b1,
                 tbl[i].drv, tbl[i].dq, tbl[i].err, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 18'(i), 1'b0, 16'($urandom_range(1, 16'hFFFE)), 1'b0,
                 1'b0, 16'h0000, 1'b0, $sformatf("fill%0d", i));
        end

        for (int i = 0; i < 600; i++) begin
            logic [17:0] ra;
            logic        rr;
            logic        rw;
            int          sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      ra = 18'h3FFFF;
            else if (sel < 3)  ra = 18'h10000 + 18'($urandom_range(0, 3));
            else               ra = 18'($urandom_range(0, 15));
            rr = ($urandom_range(0, 39) != 0);
            rw = ($urandom_range(0, 1) == 0);
            step(rr, ra, rw, 16'($urandom_range(1, 16'hFFFE)), 1'b0,
                 1'b0, 16'h0000, 1'b0, $sformatf("rnd%0d", i));
        end

        step(1'b0, 18'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "final_rst");
`ifdef SRAM_ACCESS_STATS_EN
        check("rd_count_rst", rd_count, 32'd0);
        check("wr_count_rst", wr_count, 32'd0);
`endif
        step(1'b1, 18'd0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
